// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-organised memory.
// Sub-word stores are done as read-modify-write; faulting requests never strobe memory.
module load_store_unit #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req,
    output logic                  Ready,
    input  logic                  IsStore,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] ByteAddress,
    input  logic [31:0]           StoreData,
    output logic [31:0]           LoadData,
    output logic                  Done,
    output logic                  Fault,
    output logic [ADDR_WIDTH-3:0] MemAddress,
    output logic [31:0]           MemWriteData,
    output logic                  MemReadEnable,
    output logic                  MemWriteEnable,
    input  logic [31:0]           MemReadData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic        req_store;
    logic [2:0]  req_f3;
    logic [1:0]  req_off;
    logic [31:0] req_data;

    logic        req_bad;
    logic        ready_nxt, rd_nxt, wr_nxt, done_nxt, fault_nxt;

    function automatic logic request_bad(input logic st, input logic [2:0] f3,
                                         input logic [1:0] off);
        logic legal;
        logic misaligned;
        if (st)
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        misaligned = 1'b0;
        if (f3[1:0] == 2'b01)
            misaligned = off[0];
        else if (f3[1:0] == 2'b10)
            misaligned = (off != 2'b00);
        return !legal || misaligned;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  result = {{24{b[7]}}, b};
            3'b001:  result = {{16{h[15]}}, h};
            3'b100:  result = {24'd0, b};
            3'b101:  result = {16'd0, h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace only the addressed lane(s); untouched bytes come from the word just read.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] result;
        result = word;
        case (size)
            2'b00: result[{off, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (off[1])
                    result[31:16] = data[15:0];
                else
                    result[15:0] = data[15:0];
            end
            default: result = data;
        endcase
        return result;
    endfunction

    assign req_bad = request_bad(IsStore, Funct3, ByteAddress[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            Ready          <= 1'b1;
            MemReadEnable  <= 1'b0;
            MemWriteEnable <= 1'b0;
            Done           <= 1'b0;
            Fault          <= 1'b0;
        end else begin
            state          <= state_nxt;
            Ready          <= ready_nxt;
            MemReadEnable  <= rd_nxt;
            MemWriteEnable <= wr_nxt;
            Done           <= done_nxt;
            Fault          <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Req) begin
                    if (req_bad)
                        state_nxt = S_DONE;
                    else if (!IsStore)
                        state_nxt = S_READ;
                    else if (Funct3[1:0] == 2'b10)
                        state_nxt = S_WRITE;
                    else
                        state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = req_store ? S_WRITE : S_DONE;
            S_WRITE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so strobes leave flops cleanly.
    always_comb begin
        ready_nxt = (state_nxt == S_IDLE);
        rd_nxt    = (state_nxt == S_READ);
        wr_nxt    = (state_nxt == S_WRITE);
        done_nxt  = (state_nxt == S_DONE);
        fault_nxt = (state == S_IDLE) && Req && req_bad;
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && Req) begin
            req_store <= IsStore;
            req_f3    <= Funct3;
            req_off   <= ByteAddress[1:0];
            req_data  <= StoreData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MemAddress   <= '0;
            MemWriteData <= '0;
            LoadData     <= '0;
        end else begin
            if (state == S_IDLE && Req)
                MemAddress <= ByteAddress[ADDR_WIDTH-1:2];
            if (state == S_IDLE && state_nxt == S_WRITE)
                MemWriteData <= StoreData;
            else if (state == S_READ && req_store)
                MemWriteData <= merge_store(MemReadData, req_data, req_f3[1:0], req_off);
            if (state == S_READ && !req_store)
                LoadData <= extend_load(MemReadData, req_f3, req_off);
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, busy/reset sequences, and random
// traffic checked against a byte-array memory model.
module tb_load_store_unit;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          Req = 1'b0;
    logic          IsStore = 1'b0;
    logic [2:0]    Funct3 = 3'd0;
    logic [AW-1:0] ByteAddress = '0;
    logic [31:0]   StoreData = 32'd0;
    logic          Ready, Done, Fault, MemReadEnable, MemWriteEnable;
    logic [31:0]   LoadData, MemWriteData, MemReadData;
    logic [AW-3:0] MemAddress;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .Req(Req), .Ready(Ready), .IsStore(IsStore),
        .Funct3(Funct3), .ByteAddress(ByteAddress), .StoreData(StoreData),
        .LoadData(LoadData), .Done(Done), .Fault(Fault), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemReadEnable(MemReadEnable),
        .MemWriteEnable(MemWriteEnable), .MemReadData(MemReadData)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:8191];
    assign MemReadData = mem[MemAddress];
    always @(posedge clk) if (MemWriteEnable) mem[MemAddress] = MemWriteData;

    int checks = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (MemReadEnable && MemWriteEnable) begin
            failures++;
            $display("FAIL strobe_overlap actual=both_high required=exclusive");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference memory: plain byte array, little-endian by arithmetic.
    logic [7:0] rb [0:32767];
    logic [31:0] last_ld;

    function automatic bit ref_fault(input bit st, input int f3, input int a);
        bit legal;
        int size;
        if (st) legal = (f3 <= 2);
        else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal) return 1'b1;
        size = 1 << (f3 % 4);
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int a);
        int size;
        longint v;
        size = 1 << (f3 % 4);
        v = 0;
        for (int i = 0; i < size; i++) v += longint'(rb[a + i]) * (longint'(1) << (8 * i));
        if (f3 < 2 && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    task automatic ref_store(input int f3, input int a, input logic [31:0] d);
        int size;
        logic [31:0] t;
        size = 1 << (f3 % 4);
        for (int i = 0; i < size; i++) begin
            t = (d >> (8 * i)) & 32'hFF;
            rb[a + i] = t[7:0];
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        longint v;
        v = 0;
        for (int i = 0; i < 4; i++) v += longint'(rb[4 * w + i]) * (longint'(1) << (8 * i));
        return v[31:0];
    endfunction

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [31:0] d, output int lat, output bit flt,
                          output int rd, output int wr, output bit pulse_ok);
        int n;
        @(negedge clk);
        Req = 1'b1; IsStore = st; Funct3 = f3; ByteAddress = a; StoreData = d;
        n = 0;
        while (!Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!Ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1 Req = 1'b0;
        lat = 0; rd = 0; wr = 0;
        do begin
            @(negedge clk);
            lat++;
            rd += int'(MemReadEnable);
            wr += int'(MemWriteEnable);
        end while (!Done && lat < 10);
        flt = Fault;
        @(negedge clk);
        pulse_ok = !Done && Ready;
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [14:0] a;
        logic [31:0] d;
        bit          flt;
        int          lat;
        logic [31:0] ld;
        int          rd;
        int          wr;
        logic [31:0] w6;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int lat, rd, wr, d1, d2, ndone;
        bit flt, pok;

        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        for (int i = 0; i < 32768; i++) rb[i] = 8'd0;
        last_ld = 32'd0;

        tbl[0]  = '{1'b1, 3'b010, 15'd24, 32'h80817F01, 1'b0, 2, 32'h00000000, 0, 1, 32'h80817F01};
        tbl[1]  = '{1'b0, 3'b010, 15'd24, 32'h0,        1'b0, 2, 32'h80817F01, 1, 0, 32'h80817F01};
        tbl[2]  = '{1'b0, 3'b000, 15'd25, 32'h0,        1'b0, 2, 32'h0000007F, 1, 0, 32'h80817F01};
        tbl[3]  = '{1'b0, 3'b000, 15'd27, 32'h0,        1'b0, 2, 32'hFFFFFF80, 1, 0, 32'h80817F01};
        tbl[4]  = '{1'b0, 3'b100, 15'd27, 32'h0,        1'b0, 2, 32'h00000080, 1, 0, 32'h80817F01};
        tbl[5]  = '{1'b0, 3'b001, 15'd26, 32'h0,        1'b0, 2, 32'hFFFF8081, 1, 0, 32'h80817F01};
        tbl[6]  = '{1'b0, 3'b101, 15'd26, 32'h0,        1'b0, 2, 32'h00008081, 1, 0, 32'h80817F01};
        tbl[7]  = '{1'b1, 3'b000, 15'd26, 32'h123456AA, 1'b0, 3, 32'h00008081, 1, 1, 32'h80AA7F01};
        tbl[8]  = '{1'b1, 3'b001, 15'd24, 32'hFFFF1234, 1'b0, 3, 32'h00008081, 1, 1, 32'h80AA1234};
        tbl[9]  = '{1'b0, 3'b010, 15'd24, 32'h0,        1'b0, 2, 32'h80AA1234, 1, 0, 32'h80AA1234};
        tbl[10] = '{1'b0, 3'b010, 15'd25, 32'h0,        1'b1, 1, 32'h80AA1234, 0, 0, 32'h80AA1234};
        tbl[11] = '{1'b0, 3'b001, 15'd27, 32'h0,        1'b1, 1, 32'h80AA1234, 0, 0, 32'h80AA1234};
        tbl[12] = '{1'b1, 3'b100, 15'd24, 32'hDEADBEEF, 1'b1, 1, 32'h80AA1234, 0, 0, 32'h80AA1234};
        tbl[13] = '{1'b0, 3'b010, 15'd24, 32'h0,        1'b0, 2, 32'h80AA1234, 1, 0, 32'h80AA1234};

        // Reset state
        #12;
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        chk("rst_strobes", {30'd0, MemReadEnable, MemWriteEnable}, 32'd0);
        chk("rst_loaddata", LoadData, 32'd0);
        chk("rst_wdata", MemWriteData, 32'd0);
        chk("rst_addr", 32'(MemAddress), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            do_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, lat, flt, rd, wr, pok);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d_fault", i), 32'(flt), 32'(tbl[i].flt));
            chk($sformatf("v%0d_rd_count", i), 32'(rd), 32'(tbl[i].rd));
            chk($sformatf("v%0d_wr_count", i), 32'(wr), 32'(tbl[i].wr));
            chk($sformatf("v%0d_done_pulse", i), 32'(pok), 32'd1);
            chk($sformatf("v%0d_loaddata", i), LoadData, tbl[i].ld);
            chk($sformatf("v%0d_word6", i), mem[6], tbl[i].w6);
            if (tbl[i].st && !tbl[i].flt) ref_store(int'(tbl[i].f3), int'(tbl[i].a), tbl[i].d);
        end
        last_ld = 32'h80AA1234;

        // Busy handling: Req held through two loads
        @(negedge clk);
        chk("busy_ready_start", 32'(Ready), 32'd1);
        Req = 1'b1; IsStore = 1'b0; Funct3 = 3'b010; ByteAddress = 15'd24;
        d1 = -1; d2 = -1; ndone = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                Funct3 = 3'b000;
                ByteAddress = 15'd25;
            end
            if (Done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = i;
                    chk("busy_ld1", LoadData, 32'h80AA1234);
                end else if (d2 < 0) begin
                    d2 = i;
                    chk("busy_ld2", LoadData, 32'h00000012);
                    Req = 1'b0;
                end
            end
        end
        Req = 1'b0;
        chk("busy_done_count", 32'(ndone), 32'd2);
        chk("busy_spacing", 32'(d2 - d1), 32'd3);
        last_ld = 32'h00000012;

        // Reset during the READ of a byte store
        @(negedge clk);
        Req = 1'b1; IsStore = 1'b1; Funct3 = 3'b000; ByteAddress = 15'd24; StoreData = 32'h55;
        @(posedge clk);
        #1 Req = 1'b0;
        chk("rmw_reset_in_read", 32'(MemReadEnable), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(Ready), 32'd1);
        chk("mid_rst_done_fault", {30'd0, Done, Fault}, 32'd0);
        chk("mid_rst_strobes", {30'd0, MemReadEnable, MemWriteEnable}, 32'd0);
        chk("mid_rst_loaddata", LoadData, 32'd0);
        chk("mid_rst_wdata", MemWriteData, 32'd0);
        chk("mid_rst_addr", 32'(MemAddress), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_word6", mem[6], 32'h80AA1234);
        do_req(1'b0, 3'b010, 15'd24, 32'd0, lat, flt, rd, wr, pok);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_loaddata", LoadData, 32'h80AA1234);
        last_ld = 32'h80AA1234;

        // Random traffic against the byte-level model
        for (int n = 0; n < 300; n++) begin
            bit st, ef;
            int f3, a, elat;
            logic [31:0] d;
            st = 1'($urandom_range(0, 1));
            f3 = int'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32767))
                                             : int'($urandom_range(0, 63));
            d  = $urandom;
            ef = ref_fault(st, f3, a);
            elat = ef ? 1 : (!st ? 2 : (f3 == 2 ? 2 : 3));
            do_req(st, 3'(f3), 15'(a), d, lat, flt, rd, wr, pok);
            if (!ef && !st) last_ld = ref_load(f3, a);
            if (!ef && st) ref_store(f3, a, d);
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_fault", n), 32'(flt), 32'(ef));
            chk($sformatf("rnd%0d_strobes", n), 32'(rd * 4 + wr),
                32'((ef ? 0 : ((!st || f3 != 2) ? 4 : 0)) + ((!ef && st) ? 1 : 0)));
            chk($sformatf("rnd%0d_loaddata", n), LoadData, last_ld);
            if (st) chk($sformatf("rnd%0d_word", n), mem[a / 4], ref_word(a / 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
